// File: rtl/focus_pkg.sv
// Shared definitions for the Focus front end: FSM state type, default frame
// geometry and the slice-bus element addressing helper used by both the
// slice block and the serializer.
package focus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Default geometry of one sub-sampled plane (N x N elements of W bits).
  localparam int DEF_N = 80;
  localparam int DEF_W = 16;
  localparam int N_PIX = DEF_N * DEF_N;
  localparam int CNT_W = $clog2(DEF_N);

  // Pixels per plane for an arbitrary side length.
  function automatic int pix_count(input int n);
    return n * n;
  endfunction

  // LSB position of element (m, col) on a flat slice bus. Element 0 sits in
  // the MSBs, so the raster index counts down from the top of the bus.
  function automatic int slice_elem_lsb(input int n, input int w,
                                        input int m, input int col);
    return (n * n - 1 - (m * n + col)) * w;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter for an N x N frame. Clear has priority over
// advance; the last pixel wraps both counters back to zero.
module raster_counter
  import focus_pkg::*;
#(
  parameter int N = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 advance_i,
  output logic [$clog2(N)-1:0] row_o,
  output logic [$clog2(N)-1:0] col_o,
  output logic                 last_col_o,
  output logic                 last_pix_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  assign last_col_o = (col_q == LAST);
  assign last_pix_o = last_col_o && (row_q == LAST);
  assign row_o      = row_q;
  assign col_o      = col_q;

  // Next counter values: clear, or step through the frame in raster order.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_pix_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/focus_serializer.sv
// Captures the four slice planes in one handshake and streams them out as
// 4-channel pixels in raster order with sof/eol/eof markers.
module focus_serializer
  import focus_pkg::*;
#(
  parameter int WIDTH_out_data  = 80,
  parameter int WIDTH_each_data = 16
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [WIDTH_out_data*WIDTH_out_data*WIDTH_each_data-1:0] slice_in_1,
  input  logic [WIDTH_out_data*WIDTH_out_data*WIDTH_each_data-1:0] slice_in_2,
  input  logic [WIDTH_out_data*WIDTH_out_data*WIDTH_each_data-1:0] slice_in_3,
  input  logic [WIDTH_out_data*WIDTH_out_data*WIDTH_each_data-1:0] slice_in_4,
  output logic [4*WIDTH_each_data-1:0]                           out_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic                                                   out_sof,
  output logic                                                   out_eol,
  output logic                                                   out_eof
);

  localparam int N     = WIDTH_out_data;
  localparam int W     = WIDTH_each_data;
  localparam int NPIX  = pix_count(N);
  localparam int CW    = $clog2(N);
  localparam int PIX_W = $clog2(NPIX);

  state_e state_q, state_d;

  logic          capture;
  logic          advance;
  logic          clear;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          last_col;
  logic          last_pix;

  logic [4*W-1:0] pix_in [NPIX];
  logic [4*W-1:0] buf_q  [NPIX];
  logic [PIX_W-1:0] rd_idx;

  // Regroup the four flat buses into one 4-channel word per pixel.
  genvar gi;
  generate
    for (gi = 0; gi < NPIX; gi++) begin : g_pix
      localparam int LSB = slice_elem_lsb(N, W, gi / N, gi % N);
      assign pix_in[gi] = {slice_in_1[LSB +: W], slice_in_2[LSB +: W],
                           slice_in_3[LSB +: W], slice_in_4[LSB +: W]};
    end
  endgenerate

  raster_counter #(
    .N (N)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .advance_i  (advance),
    .row_o      (row),
    .col_o      (col),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  // Next-state and control: capture in IDLE, step the raster on each transfer.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          clear   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          advance = 1'b1;
          if (last_pix) begin
            clear   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame buffer: whole frame written in one cycle, contents not reset.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      buf_q <= pix_in;
    end
  end

  assign rd_idx    = PIX_W'(row) * PIX_W'(N) + PIX_W'(col);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == STREAM);
  assign out_data  = out_valid ? buf_q[rd_idx] : '0;
  assign out_sof   = out_valid && (row == '0) && (col == '0);
  assign out_eol   = out_valid && last_col;
  assign out_eof   = out_valid && last_pix;

  // last_col feeds only the eol marker; the counter handles its own wrap.
  logic unused_ok;
  assign unused_ok = last_col;

endmodule

// File: tb/tb_focus_serializer.sv
// Self-checking bench: a small N=2/W=4 instance for handshake scenarios and a
// default N=80/W=16 instance for the full-size ramp frame.
module tb_focus_serializer;

  localparam int LN   = 80;
  localparam int LW   = 16;
  localparam int LBUS = LN * LN * LW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance signals
  logic        s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic        s_sof, s_eol, s_eof;
  logic [15:0] s_sl1, s_sl2, s_sl3, s_sl4, s_out_data;

  // Large instance signals
  logic            l_rst, l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic            l_sof, l_eol, l_eof;
  logic [LBUS-1:0] l_sl1, l_sl2, l_sl3, l_sl4;
  logic [63:0]     l_out_data;

  int n_checks = 0;
  int n_pass   = 0;

  focus_serializer #(.WIDTH_out_data(2), .WIDTH_each_data(4)) dut_s (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .slice_in_1(s_sl1), .slice_in_2(s_sl2), .slice_in_3(s_sl3), .slice_in_4(s_sl4),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sof(s_sof), .out_eol(s_eol), .out_eof(s_eof)
  );

  focus_serializer dut_l (
    .clk(clk), .rst(l_rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .slice_in_1(l_sl1), .slice_in_2(l_sl2), .slice_in_3(l_sl3), .slice_in_4(l_sl4),
    .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_sof(l_sof), .out_eol(l_eol), .out_eof(l_eof)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: element k (raster index) of a 2x2, 4-bit plane; element 0 in MSBs.
  function automatic logic [3:0] elem(input logic [15:0] b, input int k);
    return 4'(b >> ((3 - k) * 4));
  endfunction

  // Expected {in_ready, out_valid, data, sof, eol, eof} for beat k of a frame.
  function automatic logic [20:0] exp_beat(input logic [15:0] b1, b2, b3, b4,
                                           input int k);
    return {1'b0, 1'b1, elem(b1, k), elem(b2, k), elem(b3, k), elem(b4, k),
            k == 0, (k % 2) == 1, k == 3};
  endfunction

  task automatic capture_small(input string name, input logic [15:0] b1, b2, b3, b4,
                               input bit keep);
    s_sl1 = b1; s_sl2 = b2; s_sl3 = b3; s_sl4 = b4;
    s_in_valid = 1'b1;
    n_checks++;
    if ({s_in_ready, s_out_valid} !== 2'b10)
      $display("FAIL %s_capture_ready got rdy/vld=%b required 10", name,
               {s_in_ready, s_out_valid});
    else n_pass++;
    step();
    if (!keep) s_in_valid = 1'b0;
  endtask

  // Consume one frame; mode 0: ready always, 1: fixed pattern, 2: random.
  task automatic drain_small(input string name, input logic [15:0] b1, b2, b3, b4,
                             input int mode, input int exp_cycles);
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int k = 0;
    int cyc = 0;
    bit r;
    logic [20:0] got, exp;
    while (k < 4 && cyc < 64) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[cyc % 7];
        default: r = 1'($urandom_range(0, 1));
      endcase
      s_out_ready = r;
      exp = exp_beat(b1, b2, b3, b4, k);
      got = {s_in_ready, s_out_valid, s_out_data, s_sof, s_eol, s_eof};
      n_checks++;
      if (got !== exp)
        $display("FAIL %s_beat%0d got %h required %h", name, k, got, exp);
      else n_pass++;
      if (r) k++;
      step();
      cyc++;
    end
    n_checks++;
    if (k != 4 || (exp_cycles > 0 && cyc != exp_cycles))
      $display("FAIL %s_transfers got %0d beats in %0d cycles required 4 in %0d",
               name, k, cyc, exp_cycles);
    else n_pass++;
    n_checks++;
    got = {s_in_ready, s_out_valid, s_out_data, s_sof, s_eol, s_eof};
    if (got !== 21'h100000)
      $display("FAIL %s_idle got %h required %h", name, got, 21'h100000);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    s_rst = 1'b1; l_rst = 1'b1;
    s_in_valid = 1'b1; l_in_valid = 1'b0;
    s_out_ready = 1'b1; l_out_ready = 1'b1;
    s_sl1 = 16'h0123; s_sl2 = 16'h4567; s_sl3 = 16'h89AB; s_sl4 = 16'hCDEF;
    l_sl1 = '0; l_sl2 = '0; l_sl3 = '0; l_sl4 = '0;
    step();
    step();
    s_rst = 1'b0; l_rst = 1'b0; s_in_valid = 1'b0;
    step();
    got = {s_in_ready, s_out_valid, s_out_data, s_sof, s_eol, s_eof};
    n_checks++;
    if (got !== 21'h100000) $display("FAIL reset_small got %h required %h", got, 21'h100000);
    else n_pass++;
    n_checks++;
    if ({l_in_ready, l_out_valid, l_out_data, l_sof, l_eol, l_eof} !== {2'b10, 64'h0, 3'b000})
      $display("FAIL reset_large got rdy=%b vld=%b data=%h", l_in_ready, l_out_valid, l_out_data);
    else n_pass++;
  endtask

  task automatic test_basic();
    capture_small("basic", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1'b0);
    drain_small("basic", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 0, 4);
  endtask

  task automatic test_backpressure();
    capture_small("bp", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1'b0);
    drain_small("bp", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1, 7);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, a2, a3, a4, b1, b2, b3, b4;
    a1 = 16'($urandom); a2 = 16'($urandom); a3 = 16'($urandom); a4 = 16'($urandom);
    b1 = 16'($urandom); b2 = 16'($urandom); b3 = 16'($urandom); b4 = 16'($urandom);
    capture_small("b2b_a", a1, a2, a3, a4, 1'b1);
    s_sl1 = b1; s_sl2 = b2; s_sl3 = b3; s_sl4 = b4;
    drain_small("b2b_a", a1, a2, a3, a4, 0, 4);
    step();
    s_in_valid = 1'b0;
    drain_small("b2b_b", b1, b2, b3, b4, 0, 4);
  endtask

  task automatic test_reset_mid();
    logic [20:0] got, exp;
    capture_small("rmid", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1'b0);
    s_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp = exp_beat(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, k);
      got = {s_in_ready, s_out_valid, s_out_data, s_sof, s_eol, s_eof};
      n_checks++;
      if (got !== exp) $display("FAIL rmid_beat%0d got %h required %h", k, got, exp);
      else n_pass++;
      step();
    end
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    got = {s_in_ready, s_out_valid, s_out_data, s_sof, s_eol, s_eof};
    n_checks++;
    if (got !== 21'h100000) $display("FAIL rmid_after_rst got %h required %h", got, 21'h100000);
    else n_pass++;
    capture_small("rmid_new", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1'b0);
    drain_small("rmid_new", 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 0, 4);
  endtask

  task automatic test_random();
    logic [15:0] b1, b2, b3, b4;
    for (int f = 0; f < 8; f++) begin
      b1 = 16'($urandom); b2 = 16'($urandom); b3 = 16'($urandom); b4 = 16'($urandom);
      capture_small("rand", b1, b2, b3, b4, 1'b0);
      drain_small("rand", b1, b2, b3, b4, 2, 0);
    end
  endtask

  task automatic test_large();
    logic [63:0] exp_d, got_d;
    logic [2:0]  exp_m, got_m;
    int idx;
    for (int m = 0; m < LN; m++) begin
      for (int n = 0; n < LN; n++) begin
        idx = m * LN + n;
        l_sl1[(LN*LN-1-idx)*LW +: LW] = {2'd0, 14'(idx)};
        l_sl2[(LN*LN-1-idx)*LW +: LW] = {2'd1, 14'(idx)};
        l_sl3[(LN*LN-1-idx)*LW +: LW] = {2'd2, 14'(idx)};
        l_sl4[(LN*LN-1-idx)*LW +: LW] = {2'd3, 14'(idx)};
      end
    end
    l_in_valid = 1'b1;
    l_out_ready = 1'b1;
    n_checks++;
    if (l_in_ready !== 1'b1) $display("FAIL large_capture_ready got %b required 1", l_in_ready);
    else n_pass++;
    step();
    l_in_valid = 1'b0;
    for (int k = 0; k < LN * LN; k++) begin
      exp_d = {2'd0, 14'(k), 2'd1, 14'(k), 2'd2, 14'(k), 2'd3, 14'(k)};
      exp_m = {k == 0, (k % LN) == LN - 1, k == LN * LN - 1};
      got_d = l_out_data;
      got_m = {l_sof, l_eol, l_eof};
      n_checks++;
      if (l_out_valid !== 1'b1 || got_d !== exp_d || got_m !== exp_m)
        $display("FAIL large_beat%0d got vld=%b data=%h sof/eol/eof=%b required vld=1 data=%h sof/eol/eof=%b",
                 k, l_out_valid, got_d, got_m, exp_d, exp_m);
      else n_pass++;
      step();
    end
    n_checks++;
    if ({l_in_ready, l_out_valid, l_sof, l_eol, l_eof} !== 5'b10000)
      $display("FAIL large_idle got rdy=%b vld=%b markers=%b required rdy=1 vld=0 markers=000",
               l_in_ready, l_out_valid, {l_sof, l_eol, l_eof});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_large();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/focus_serializer.md
# focus_serializer

Downstream stage of the slice (space-to-depth) block in the Focus front end. Captures the four registered sub-sampled planes in one handshake and streams them out in raster order, one 4-channel pixel per beat, to the following convolution stage. Replaces the flat-bus interface with a valid/ready pixel stream carrying start-of-frame, end-of-line and end-of-frame markers.

## Interface
- WIDTH_out_data, default 80: side length N of each input plane, N ≥ 2.
- WIDTH_each_data, default 16: element width W in bits.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  the four slice buses hold a complete frame.
- in_ready  output  1  block idle and able to capture.
- slice_in_1..slice_in_4  input  N*N*W each  planes (even,even), (even,odd), (odd,even), (odd,odd). Element (m,n) sits at bits [(N*N*W-1) - (m*N+n)*W -: W].
- out_data  output  4*W  {plane1, plane2, plane3, plane4} element (m,n); plane1 in the MSBs.
- out_valid  input/output: output, 1 bit, beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_sof  output  1  beat is (0,0).
- out_eol  output  1  beat has n = N-1.
- out_eof  output  1  beat is (N-1,N-1).

## Operation
- Two states.
  - IDLE: in_ready=1, out_valid=0.
  - STREAM: in_ready=0, out_valid=1.
- IDLE, in_valid=1: capture all four buses into an internal frame buffer (4*N*N*W bits), clear row/col counters, go to STREAM.
- STREAM: out_data = buffered element (row,col) of each plane.
  - Beat transfers when out_valid && out_ready.
  - On transfer: col increments; at col = N-1, col wraps to 0 and row increments.
  - Transfer with row = col = N-1 (eof beat): go to IDLE and clear counters.
- Markers are functions of the counters only:
  - out_sof = (row==0 && col==0)
  - out_eol = (col==N-1)
  - out_eof = out_eol && (row==N-1)
  - Markers are gated by out_valid.
- Stall: while out_valid && !out_ready, out_data and all markers hold stable.
- in_valid is ignored in STREAM. The producer holds its buses and in_valid until in_ready. Bus changes during STREAM do not affect the frame in flight.
- Buffer implementation: either a shift register (shift by W per transfer) or indexed read. Both must be cycle-identical at the ports.
- No arithmetic on data; all elements pass bit-exact.
- Counter width: $clog2(N). Counters never exceed N-1.

## Timing
- Reset, all synchronous:
  - state=IDLE; in_ready=1 from the first cycle after rst is sampled high.
  - out_valid=0, out_sof=0, out_eol=0, out_eof=0; out_data=0; counters=0.
  - Buffer contents are don't-care.
- Latency: capture accepted at edge t, so out_valid=1 with beat (0,0) in cycle t+1.
- Throughput: one beat per cycle with out_ready held high. A frame takes N*N beats plus 1 idle cycle.
- Eof transfer at edge t:
  - in_ready=1 in cycle t+1.
  - A waiting in_valid is captured at edge t+1.
  - The next sof beat is valid in cycle t+2.
  - in_valid high in the eof cycle itself is not accepted.
- rst mid-frame overrides everything. Next cycle: IDLE, out_valid=0. The partial frame is discarded, and the next frame restarts at sof.
- rst and in_valid in the same cycle: reset wins, no capture.

## Structure
- Shared package focus_pkg:
  - state typedef (IDLE, STREAM).
  - localparams N_PIX = N*N and CNT_W = $clog2(N).
  - Slice-bus element-index helper shared with the slice block.
- One sub-module, raster_counter: row/col counters with advance, clear, last_col and last_pix outputs. Reused by later line-buffer stages.

## Test plan
- Reset: rst high 2 cycles, then low.
  - Cycle after reset: in_ready=1, out_valid=0, all markers 0, out_data=0.
- Basic frame, N=2, W=4, out_ready=1:
  - Stimulus: slice_in_1=16'h0123, slice_in_2=16'h4567, slice_in_3=16'h89AB, slice_in_4=16'hCDEF.
  - Required beats in consecutive cycles from t+1:
    - 16'h048C (sof)
    - 16'h159D (eol)
    - 16'h26AE
    - 16'h37BF (eol, eof)
  - Then in_ready=1.
- Backpressure, same frame, out_ready pattern 1,0,0,1,0,1,1:
  - Each beat is held stable through the stalls.
  - Exactly 4 transfers, in the same order and with the same markers.
- Back-to-back frames, in_valid held high, buses changed during STREAM:
  - First frame unaffected.
  - Second frame captured in the cycle after the eof transfer.
  - Its sof beat appears one cycle later.
- Reset mid-frame, rst after 2 transfers:
  - Next cycle out_valid=0, in_ready=1.
  - A new capture restarts at 16'h048C with sof.
- Default params, N=80, W=16, ramp data (element value = m*80+n, plane index in the top bits):
  - 6400 beats, bit-exact.
  - eol every 80th beat; single eof on beat 6400.
